// File: rtl/add_inverse_if.sv
// Handshake bundle for add_inverse: (C, B) request side and (A, ovf, unf) response side.
// The master drives requests and consumes responses; the slave is the recovery pipeline.
interface add_inverse_if #(
  parameter int AW = 21,
  parameter int BW = 18,
  parameter int CW = 23
) ();
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] C_in;
  logic [BW-1:0] B_in;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] A_out;
  logic          ovf;
  logic          unf;

  modport master (
    output in_valid, C_in, B_in, out_ready,
    input  in_ready, out_valid, A_out, ovf, unf
  );

  modport slave (
    input  in_valid, C_in, B_in, out_ready,
    output in_ready, out_valid, A_out, ovf, unf
  );
endinterface

// File: rtl/add_inverse.sv
// Two-stage pipeline recovering unsigned A = C - B from a signed sum and signed addend,
// clamped to the A range with over/underflow flags and a saturating clamp-event counter.
module add_inverse #(
  parameter int AW    = 21,
  parameter int BW    = 18,
  parameter int CW    = 23,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  add_inverse_if.slave     bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  // One extra bit over the wider operand keeps C - B exact for every input pair.
  localparam int              DW      = ((CW > BW) ? CW : BW) + 1;
  localparam logic [DW-1:0]    A_MAX   = DW'({AW{1'b1}});
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Packs {ovf, unf, A} for a full-precision difference.
  function automatic logic [AW+1:0] clamp_f(input logic [DW-1:0] d);
    logic [AW+1:0] r;
    if (d[DW-1]) begin
      r = {1'b0, 1'b1, {AW{1'b0}}};
    end else if (d > A_MAX) begin
      r = {1'b1, 1'b0, {AW{1'b1}}};
    end else begin
      r = {1'b0, 1'b0, d[AW-1:0]};
    end
    return r;
  endfunction

  logic [DW-1:0]    c_ext_s;
  logic [DW-1:0]    b_ext_s;
  logic [DW-1:0]    diff_s;
  logic             s1_adv_s;
  logic             s2_adv_s;
  logic             sat_event_s;

  logic             s1_valid_r;
  logic [DW-1:0]    diff_r;
  logic             s2_valid_r;
  logic [AW-1:0]    a_r;
  logic             ovf_r;
  logic             unf_r;
  logic [CNT_W-1:0] sat_cnt_r;

  assign c_ext_s = {{(DW-CW){bus.C_in[CW-1]}}, bus.C_in};
  assign b_ext_s = {{(DW-BW){bus.B_in[BW-1]}}, bus.B_in};
  assign diff_s  = c_ext_s - b_ext_s;

  // Ready depends only on downstream ready and occupancy, never on in_valid.
  assign s2_adv_s    = !s2_valid_r || bus.out_ready;
  assign s1_adv_s    = !s1_valid_r || s2_adv_s;
  assign sat_event_s = s2_valid_r && bus.out_ready && (ovf_r || unf_r);

  assign bus.in_ready  = s1_adv_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.A_out     = a_r;
  assign bus.ovf       = ovf_r;
  assign bus.unf       = unf_r;
  assign sat_cnt       = sat_cnt_r;

  // Pipeline registers; result registers only load on a valid S1 so they hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      diff_r     <= {DW{1'b0}};
      s2_valid_r <= 1'b0;
      a_r        <= {AW{1'b0}};
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s1_valid_r <= bus.in_valid;
        if (bus.in_valid) begin
          diff_r <= diff_s;
        end
      end
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          {ovf_r, unf_r, a_r} <= clamp_f(diff_r);
        end
      end
    end
  end

  // Saturating count of clamped results leaving the block; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      sat_cnt_r <= {CNT_W{1'b0}};
    end else if (sat_event_s && (sat_cnt_r != CNT_MAX)) begin
      sat_cnt_r <= sat_cnt_r + CNT_ONE;
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end

endmodule

// File: tb/tb_add_inverse.sv
// Directed-vector bench for add_inverse: clamping, backpressure, counter saturation and reset.
// A second instance with a 2-bit counter exercises counter saturation and clear priority.
module tb_add_inverse;

  logic clk;
  logic rst_n;
  logic cnt_clr;
  logic cnt_clr_c;
  logic [15:0] sat_cnt;
  logic [1:0]  sat_cnt_c;

  int n_vec;
  int n_err;
  int cnt_exp;

  add_inverse_if #(.AW(21), .BW(18), .CW(23)) ifc ();
  add_inverse_if #(.AW(21), .BW(18), .CW(23)) ifc_c ();

  add_inverse #(.AW(21), .BW(18), .CW(23), .CNT_W(16)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc),
    .cnt_clr (cnt_clr),
    .sat_cnt (sat_cnt)
  );

  add_inverse #(.AW(21), .BW(18), .CW(23), .CNT_W(2)) u_dut_c (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc_c),
    .cnt_clr (cnt_clr_c),
    .sat_cnt (sat_cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int c, input int b);
    logic [31:0] cv;
    logic [31:0] bv;
    cv = c;
    bv = b;
    ifc.C_in = cv[22:0];
    ifc.B_in = bv[17:0];
  endtask

  // Offer one item with out_ready=1, check the result one edge after acceptance and the counter after it leaves.
  task automatic apply(input string tag, input int c, input int b,
                       input int exp_a, input logic exp_o, input logic exp_u);
    @(negedge clk);
    drive(c, b);
    ifc.in_valid = 1'b1;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk({tag, "_s1_not_out"}, 32'(ifc.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(ifc.out_valid), 32'd1);
    chk({tag, "_a"}, 32'(ifc.A_out), exp_a);
    chk({tag, "_ovf"}, 32'(ifc.ovf), 32'(exp_o));
    chk({tag, "_unf"}, 32'(ifc.unf), 32'(exp_u));
    if (exp_o || exp_u) cnt_exp++;
    @(negedge clk);
    chk({tag, "_drained"}, 32'(ifc.out_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(sat_cnt), 32'(cnt_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    cnt_exp = 0;
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    cnt_clr_c = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.C_in = 23'd0;
    ifc.B_in = 18'd0;
    ifc_c.in_valid = 1'b0;
    ifc_c.out_ready = 1'b1;
    ifc_c.C_in = 23'd0;
    ifc_c.B_in = 18'd0;

    #2;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_a", 32'(ifc.A_out), 32'd0);
    chk("rst_flags", 32'({ifc.ovf, ifc.unf}), 32'd0);
    chk("rst_cnt", 32'(sat_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);

    apply("nominal",   100,       -5,      105,     1'b0, 1'b0);
    apply("underflow", -10,       3,       0,       1'b0, 1'b1);
    apply("zero",      3,         3,       0,       1'b0, 1'b0);
    apply("overflow",  4194303,   -131072, 2097151, 1'b1, 1'b0);
    apply("amax",      2097151,   0,       2097151, 1'b0, 1'b0);
    apply("deep_unf",  -4194304,  131071,  0,       1'b0, 1'b1);
    apply("mid",       1000000,   -200,    1000200, 1'b0, 1'b0);

    // Backpressure: two items fill the pipe, the third waits for space.
    @(negedge clk);
    ifc.out_ready = 1'b0;
    drive(10, 0);
    ifc.in_valid = 1'b1;
    chk("bp_rdy0", 32'(ifc.in_ready), 32'd1);
    @(negedge clk);
    chk("bp_rdy1", 32'(ifc.in_ready), 32'd1);
    drive(20, 0);
    @(negedge clk);
    chk("bp_full", 32'(ifc.in_ready), 32'd0);
    chk("bp_v10", 32'(ifc.out_valid), 32'd1);
    chk("bp_a10", 32'(ifc.A_out), 32'd10);
    drive(30, 0);
    @(negedge clk);
    chk("bp_hold_a", 32'(ifc.A_out), 32'd10);
    chk("bp_hold_v", 32'(ifc.out_valid), 32'd1);
    chk("bp_hold_rdy", 32'(ifc.in_ready), 32'd0);
    ifc.out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", 32'(ifc.in_ready), 32'd1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("bp_a20", 32'(ifc.A_out), 32'd20);
    chk("bp_v20", 32'(ifc.out_valid), 32'd1);
    @(negedge clk);
    chk("bp_a30", 32'(ifc.A_out), 32'd30);
    chk("bp_v30", 32'(ifc.out_valid), 32'd1);
    @(negedge clk);
    chk("bp_empty", 32'(ifc.out_valid), 32'd0);
    chk("bp_keep_a", 32'(ifc.A_out), 32'd30);

    // 2-bit counter: five back-to-back underflows saturate at 3.
    @(negedge clk);
    ifc_c.C_in = 23'h7FFFFF;
    ifc_c.B_in = 18'd0;
    ifc_c.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    ifc_c.in_valid = 1'b0;
    @(negedge clk);
    chk("c_after3", 32'(sat_cnt_c), 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk("c_sat", 32'(sat_cnt_c), 32'd3);
    chk("c_drained", 32'(ifc_c.out_valid), 32'd0);
    ifc_c.in_valid = 1'b1;
    @(negedge clk);
    ifc_c.in_valid = 1'b0;
    @(negedge clk);
    chk("c_item_out", 32'(ifc_c.out_valid), 32'd1);
    chk("c_item_unf", 32'(ifc_c.unf), 32'd1);
    cnt_clr_c = 1'b1;
    @(negedge clk);
    cnt_clr_c = 1'b0;
    chk("c_clr_prio", 32'(sat_cnt_c), 32'd0);
    @(negedge clk);
    chk("c_clr_stay", 32'(sat_cnt_c), 32'd0);

    // Reset while both stages hold data.
    @(negedge clk);
    ifc.out_ready = 1'b0;
    drive(-1, 0);
    ifc.in_valid = 1'b1;
    @(negedge clk);
    drive(5, 0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("mr_full_v", 32'(ifc.out_valid), 32'd1);
    chk("mr_full_rdy", 32'(ifc.in_ready), 32'd0);
    chk("mr_cnt_pre", 32'(sat_cnt), 32'(cnt_exp));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_v", 32'(ifc.out_valid), 32'd0);
    chk("mr_a", 32'(ifc.A_out), 32'd0);
    chk("mr_cnt", 32'(sat_cnt), 32'd0);
    cnt_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    chk("mr_rdy", 32'(ifc.in_ready), 32'd1);
    apply("post_rst", 7, 2, 5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
